// File: rtl/mbfifo_sync.sv
// mbfifo_sync -- single-clock multi-buffer block FIFO.
//
// BUFFER_COUNT buffers of 2^ADDRESS_WIDTH words each share one RAM addressed
// {buffer index, pointer}. The writer claims an empty buffer with a one-hot
// write_activate, streams words into it and commits it by dropping the bit.
// Committed buffer indices queue up and are handed to the reader in commit
// order. The reader sees the first word immediately (fall-through), takes
// ownership with read_activate, and releases the buffer by dropping it.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   write_ready        per-buffer "empty and claimable"
//   write_activate     one-hot claim of a buffer, held for the whole block
//   write_fifo_size    words per buffer (constant)
//   write_strobe/data  store one word into the claimed buffer
//   starved            no committed block waiting in the queue
//   read_ready         a committed block is offered to the reader
//   read_activate      reader owns the offered block
//   read_count         word count of the offered/owned block
//   read_strobe/data   consume the current word / current word
//
// Optional build macro MBFIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags and an err_clear input.
module mbfifo_sync #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int BUFFER_COUNT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [BUFFER_COUNT-1:0] write_ready,
    input  logic [BUFFER_COUNT-1:0] write_activate,
    output logic [23:0]             write_fifo_size,
    input  logic                    write_strobe,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    starved,
    output logic                    read_ready,
    input  logic                    read_activate,
    output logic [23:0]             read_count,
    input  logic                    read_strobe,
    output logic [DATA_WIDTH-1:0]   read_data
`ifdef MBFIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clear
`endif
);
    localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
    localparam int IW         = $clog2(BUFFER_COUNT);
    localparam int CW         = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_COMMITTED, BUF_READING} buf_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_OFFERED, RD_OWNED} rd_state_t;

    // Claim decode: multi-bit activate vectors freeze every buffer.
    logic act_any, act_onehot, act_multi;
    assign act_any    = |write_activate;
    assign act_onehot = act_any && ((write_activate & (write_activate - BUFFER_COUNT'(1))) == '0);
    assign act_multi  = act_any && !act_onehot;

    logic [BUFFER_COUNT-1:0]                    commit_vec;
    logic [BUFFER_COUNT-1:0]                    write_hit_vec;
    logic [BUFFER_COUNT-1:0][CW-1:0]            buf_count;
    logic [BUFFER_COUNT-1:0][ADDRESS_WIDTH-1:0] buf_wptr;
`ifdef MBFIFO_ERR_FLAGS_EN
    logic [BUFFER_COUNT-1:0]                    drop_vec;
`endif

    // Read-side / queue handshake signals used by the buffer FSMs.
    rd_state_t       rd_state_reg, rd_state_next;
    logic [IW-1:0]   rd_index_reg;
    logic [CW-1:0]   rd_ptr_reg, rd_count_reg;
    logic [DATA_WIDTH-1:0] rd_hold_reg;
    logic            pop, release_buf, rd_accept;
    logic [IW-1:0]   q_mem_reg [BUFFER_COUNT];
    logic [IW-1:0]   q_head_reg, q_tail_reg;
    logic [IW:0]     q_count_reg;
    logic [IW-1:0]   head_idx;

    assign head_idx = q_mem_reg[q_head_reg];

    // ------------------------------------------------------------------
    // Per-buffer state machines
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_COUNT; gi++) begin : g_buf
            buf_state_t    state_reg, state_next;
            logic [CW-1:0] count_reg, count_next;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= BUF_EMPTY;
                    count_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                end
            end

            always_comb begin
                state_next        = state_reg;
                count_next        = count_reg;
                commit_vec[gi]    = 1'b0;
                write_hit_vec[gi] = 1'b0;
                case (state_reg)
                    BUF_EMPTY: begin
                        if (act_onehot && write_activate[gi]) begin
                            state_next = BUF_FILLING;
                            count_next = '0;
                            if (write_strobe) begin
                                write_hit_vec[gi] = 1'b1;
                                count_next        = CW'(1);
                            end
                        end
                    end
                    BUF_FILLING: begin
                        if (!act_multi) begin
                            if (!write_activate[gi]) begin
                                if (count_reg != '0) begin
                                    state_next     = BUF_COMMITTED;
                                    commit_vec[gi] = 1'b1;
                                end else begin
                                    state_next = BUF_EMPTY;
                                end
                            end else if (write_strobe && count_reg != CW'(FIFO_DEPTH)) begin
                                write_hit_vec[gi] = 1'b1;
                                count_next        = count_reg + CW'(1);
                            end
                        end
                    end
                    BUF_COMMITTED: begin
                        if (pop && head_idx == IW'(gi))
                            state_next = BUF_READING;
                    end
                    default: begin
                        if (release_buf && rd_index_reg == IW'(gi))
                            state_next = BUF_EMPTY;
                    end
                endcase
            end

            assign write_ready[gi] = (state_reg == BUF_EMPTY);
            assign buf_count[gi]   = count_reg;
            // A claim always starts writing at word 0, whatever count_reg holds.
            assign buf_wptr[gi]    = (state_reg == BUF_EMPTY) ? '0 : count_reg[ADDRESS_WIDTH-1:0];
`ifdef MBFIFO_ERR_FLAGS_EN
            assign drop_vec[gi]    = (state_reg == BUF_FILLING) && !act_multi && write_activate[gi]
                                     && write_strobe && (count_reg == CW'(FIFO_DEPTH));
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared storage: at most one buffer is filling, so one write port.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]         ram [BUFFER_COUNT*FIFO_DEPTH];
    logic                          wr_en;
    logic [IW+ADDRESS_WIDTH-1:0]   wr_addr, rd_addr;
    logic                          push;
    logic [IW-1:0]                 push_idx;

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        push     = 1'b0;
        push_idx = '0;
        for (int i = 0; i < BUFFER_COUNT; i++) begin
            if (write_hit_vec[i]) begin
                wr_en   = 1'b1;
                wr_addr = {IW'(i), buf_wptr[i]};
            end
            if (commit_vec[i]) begin
                push     = 1'b1;
                push_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= write_data;
    end

    // ------------------------------------------------------------------
    // Commit queue of buffer indices; depth equals the buffer count, so
    // it can never overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)
            q_mem_reg[q_tail_reg] <= push_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_head_reg  <= '0;
            q_tail_reg  <= '0;
            q_count_reg <= '0;
        end else begin
            if (push)
                q_tail_reg <= (q_tail_reg == IW'(BUFFER_COUNT - 1)) ? '0 : q_tail_reg + IW'(1);
            if (pop)
                q_head_reg <= (q_head_reg == IW'(BUFFER_COUNT - 1)) ? '0 : q_head_reg + IW'(1);
            if (push && !pop)
                q_count_reg <= q_count_reg + (IW+1)'(1);
            else if (pop && !push)
                q_count_reg <= q_count_reg - (IW+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign pop         = (rd_state_reg == RD_IDLE) && !read_activate && (q_count_reg != '0);
    assign release_buf = (rd_state_reg == RD_OWNED) && !read_activate;
    assign rd_accept   = read_strobe && read_activate && (rd_state_reg != RD_IDLE)
                         && (rd_ptr_reg != rd_count_reg);

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE:    if (pop)            rd_state_next = RD_OFFERED;
            RD_OFFERED: if (read_activate)  rd_state_next = RD_OWNED;
            default:    if (!read_activate) rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg <= RD_IDLE;
            rd_index_reg <= '0;
            rd_ptr_reg   <= '0;
            rd_count_reg <= '0;
            rd_hold_reg  <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            if (rd_state_reg != RD_IDLE)
                rd_hold_reg <= read_data;
            if (pop) begin
                rd_index_reg <= head_idx;
                rd_ptr_reg   <= '0;
                rd_count_reg <= buf_count[head_idx];
            end else if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + CW'(1);
            end
        end
    end

    assign rd_addr         = {rd_index_reg, rd_ptr_reg[ADDRESS_WIDTH-1:0]};
    assign read_data       = (rd_state_reg != RD_IDLE) ? ram[rd_addr] : rd_hold_reg;
    assign read_ready      = (rd_state_reg == RD_OFFERED);
    assign read_count      = 24'(rd_count_reg);
    assign starved         = (q_count_reg == '0);
    assign write_fifo_size = 24'(FIFO_DEPTH);

`ifdef MBFIFO_ERR_FLAGS_EN
    logic overflow_reg, underflow_reg;

    // A new event in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (|drop_vec)
                overflow_reg <= 1'b1;
            else if (err_clear)
                overflow_reg <= 1'b0;
            if (read_strobe && !rd_accept)
                underflow_reg <= 1'b1;
            else if (err_clear)
                underflow_reg <= 1'b0;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif
endmodule
